// File: rtl/cordic_pkg.sv
// Shared constants and types for the serial CORDIC phase engine.
//   ATAN     : atan(2^-i) as a 32-bit binary angle (2^32 = 360 deg), i = 0..29
//   ANG_90   : +90 deg binary angle
//   ANG_M90  : -90 deg binary angle
//   state_e  : sequencer states LOAD -> ITER -> DONE
package cordic_pkg;

  typedef enum logic [1:0] {
    LOAD,
    ITER,
    DONE
  } state_e;

  localparam logic [31:0] ANG_90  = 32'h4000_0000;
  localparam logic [31:0] ANG_M90 = 32'hC000_0000;

  localparam int unsigned ATAN_N = 30;

  // round(atan(2^-i) * 2^32 / (2*pi))
  localparam logic [31:0] ATAN [ATAN_N] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4, 32'h028B_0D43,
    32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55, 32'h0028_BE53, 32'h0014_5F2F,
    32'h000A_2F98, 32'h0005_17CC, 32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA,
    32'h0000_517D, 32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
    32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051, 32'h0000_0029,
    32'h0000_0014, 32'h0000_000A, 32'h0000_0005, 32'h0000_0003, 32'h0000_0001
  };

endpackage

// File: rtl/cordic_stage_comb.sv
// One vectoring-mode CORDIC micro-rotation, purely combinational.
//   xi_i, yi_i : current vector (WIDTH+2 bits, signed)
//   z_i        : accumulated angle (binary angle, wraps)
//   i_i        : iteration index (shift amount / ATAN entry)
//   xi_o, yi_o, z_o : vector and angle after the rotation
// The rotation direction drives yi toward zero; z accumulates the angle removed.
module cordic_stage_comb
  import cordic_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic signed [WIDTH+1:0] xi_i,
  input  logic signed [WIDTH+1:0] yi_i,
  input  logic        [WIDTH-1:0] z_i,
  input  logic        [4:0]       i_i,
  output logic signed [WIDTH+1:0] xi_o,
  output logic signed [WIDTH+1:0] yi_o,
  output logic        [WIDTH-1:0] z_o
);

  logic signed [WIDTH+1:0] x_sh;
  logic signed [WIDTH+1:0] y_sh;
  logic        [31:0]      atan_full;
  logic        [WIDTH-1:0] atan_i;

  assign x_sh      = xi_i >>> i_i;
  assign y_sh      = yi_i >>> i_i;
  assign atan_full = ATAN[i_i];
  // Binary angles scale by truncation: keep the top WIDTH bits.
  assign atan_i    = atan_full[31 -: WIDTH];

  always_comb begin
    xi_o = xi_i;
    yi_o = yi_i;
    z_o  = z_i;
    if (!yi_i[WIDTH+1]) begin
      xi_o = xi_i + y_sh;
      yi_o = yi_i - x_sh;
      z_o  = z_i + atan_i;
    end else begin
      xi_o = xi_i - y_sh;
      yi_o = yi_i + x_sh;
      z_o  = z_i - atan_i;
    end
  end

endmodule

// File: rtl/cordic_serial.sv
// Free-running iterative CORDIC (vectoring mode): phase = atan2(y, x) as a
// full-circle binary angle. One micro-rotation per clock, period ITERS+2.
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   x, y        : signed input vector, sampled in LOAD only
//   phase       : binary angle, 2^WIDTH = 360 deg, held between updates
//   phase_valid : one-cycle pulse coincident with each phase update
module cordic_serial
  import cordic_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITERS = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] phase,
  output logic             phase_valid
);

  localparam int unsigned XW       = WIDTH + 2;
  localparam logic [4:0]  IterLast = 5'(ITERS - 1);
  localparam logic [WIDTH-1:0] Ang90  = ANG_90[31 -: WIDTH];
  localparam logic [WIDTH-1:0] AngM90 = ANG_M90[31 -: WIDTH];

  state_e                 state_q, state_d;
  logic [4:0]             cnt_q, cnt_d;
  logic signed [XW-1:0]   xi_q, xi_d, yi_q, yi_d;
  logic [WIDTH-1:0]       z_q, z_d;
  logic                   zero_q, zero_d;
  logic [WIDTH-1:0]       phase_q, phase_d;
  logic                   valid_q, valid_d;

  logic signed [XW-1:0]   x_ext, y_ext;
  logic signed [XW-1:0]   xi_nx, yi_nx;
  logic [WIDTH-1:0]       z_nx;

  // Two guard bits make -(most negative input) exact and absorb CORDIC growth.
  assign x_ext = {{2{x[WIDTH-1]}}, x};
  assign y_ext = {{2{y[WIDTH-1]}}, y};

  cordic_stage_comb #(
    .WIDTH (WIDTH)
  ) u_stage (
    .xi_i (xi_q),
    .yi_i (yi_q),
    .z_i  (z_q),
    .i_i  (cnt_q),
    .xi_o (xi_nx),
    .yi_o (yi_nx),
    .z_o  (z_nx)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    xi_d    = xi_q;
    yi_d    = yi_q;
    z_d     = z_q;
    zero_d  = zero_q;
    phase_d = phase_q;
    valid_d = 1'b0;
    unique case (state_q)
      LOAD: begin
        // The zero vector has no angle; iterating it would drift z, so flag it.
        zero_d = (x == '0) && (y == '0);
        // Pre-rotate the left half-plane by +/-90 deg into x >= 0.
        if (!x[WIDTH-1]) begin
          xi_d = x_ext;
          yi_d = y_ext;
          z_d  = '0;
        end else if (!y[WIDTH-1]) begin
          xi_d = y_ext;
          yi_d = -x_ext;
          z_d  = Ang90;
        end else begin
          xi_d = -y_ext;
          yi_d = x_ext;
          z_d  = AngM90;
        end
        cnt_d   = '0;
        state_d = ITER;
      end
      ITER: begin
        xi_d = xi_nx;
        yi_d = yi_nx;
        z_d  = z_nx;
        if (cnt_q == IterLast) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      DONE: begin
        phase_d = zero_q ? '0 : z_q;
        valid_d = 1'b1;
        state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      xi_q    <= '0;
      yi_q    <= '0;
      z_q     <= '0;
      zero_q  <= 1'b0;
      phase_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      xi_q    <= xi_d;
      yi_q    <= yi_d;
      z_q     <= z_d;
      zero_q  <= zero_d;
      phase_q <= phase_d;
      valid_q <= valid_d;
    end
  end

  assign phase       = phase_q;
  assign phase_valid = valid_q;

endmodule

// File: tb/tb_cordic_serial.sv
// Scoreboard bench for cordic_serial: the stimulus process aligns each vector
// to a LOAD edge and queues the expected angle; a monitor pops and compares on
// every phase_valid pulse, and also checks pulse latency and period.
module tb_cordic_serial;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned ITERS  = 24;
  localparam int          PERIOD = ITERS + 2;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] phase;
  logic             phase_valid;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q  [$];
  int          tol_q  [$];
  string       name_q [$];

  int cyc;
  int last_cyc;
  bit seen_since_rst;

  cordic_serial #(
    .WIDTH (WIDTH),
    .ITERS (ITERS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .x           (x),
    .y           (y),
    .phase       (phase),
    .phase_valid (phase_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising edges since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_angle(input string name, input logic [31:0] act,
                             input logic [31:0] expv, input int tol);
    logic [31:0] diff;
    int          d;
    diff = act - expv;
    d    = $signed(diff);
    if (d < 0) d = -d;
    n_checks++;
    if (d > tol) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h +/-%0d", name, act, expv, tol);
    end
  endtask

  task automatic check_int(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, expv);
    end
  endtask

  // Monitor: compares every published result against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && phase_valid) begin
        if (!seen_since_rst) check_int("first_valid_latency", cyc, PERIOD);
        else                 check_int("valid_period", cyc - last_cyc, PERIOD);
        seen_since_rst = 1'b1;
        last_cyc       = cyc;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_valid: got phase 0x%08h, want no pulse", phase);
        end else begin
          check_angle(name_q.pop_front(), phase, exp_q.pop_front(), tol_q.pop_front());
        end
      end
    end
  end

  task automatic push_exp(input logic [31:0] e, input int tol, input string name);
    exp_q.push_back(e);
    tol_q.push_back(tol);
    name_q.push_back(name);
  endtask

  // Call at the negedge preceding a LOAD edge; returns at the next such negedge.
  task automatic conv(input logic [31:0] xv, input logic [31:0] yv,
                      input logic [31:0] e, input int tol, input string name);
    x = xv;
    y = yv;
    push_exp(e, tol, name);
    repeat (PERIOD) @(negedge clk);
  endtask

  // Inputs change 5 cycles into the conversion; only the captured pair counts.
  task automatic conv_mid(input logic [31:0] xa, input logic [31:0] ya,
                          input logic [31:0] ea, input logic [31:0] xb,
                          input logic [31:0] yb, input string name);
    x = xa;
    y = ya;
    push_exp(ea, 1024, name);
    repeat (5) @(negedge clk);
    x = xb;
    y = yb;
    repeat (PERIOD - 5) @(negedge clk);
  endtask

  localparam logic [31:0] P1M = 32'sd1000000;
  localparam logic [31:0] N1M = -32'sd1000000;

  initial begin
    x              = '0;
    y              = '0;
    seen_since_rst = 1'b0;
    last_cyc       = 0;
    rst_n          = 1'b1;
    #1 rst_n       = 1'b0;
    repeat (2) @(negedge clk);
    check_angle("reset_phase", phase, 32'h0, 0);
    check_int("reset_valid", int'(phase_valid), 0);
    rst_n = 1'b1;

    conv('0, '0, 32'h0000_0000, 0, "zero_vector");
    conv(P1M, P1M, 32'h2000_0000, 1024, "q1_45deg_a");
    conv(P1M, P1M, 32'h2000_0000, 1024, "q1_45deg_b");
    conv(P1M, '0, 32'h0000_0000, 1024, "pos_x_axis");
    conv(P1M, N1M, 32'hE000_0000, 1024, "q4_m45deg");
    conv('0, P1M, 32'h4000_0000, 1024, "pos_y_axis");
    conv('0, N1M, 32'hC000_0000, 1024, "neg_y_axis");
    conv(N1M, '0, 32'h8000_0000, 1024, "neg_x_axis");
    conv(N1M, N1M, 32'hA000_0000, 1024, "q3_m135deg");
    conv(N1M, P1M, 32'h6000_0000, 1024, "q2_135deg");
    conv(32'h8000_0000, 32'h8000_0000, 32'hA000_0000, 1024, "most_negative");
    conv('0, '0, 32'h0000_0000, 0, "zero_again");

    conv_mid(P1M, '0, 32'h0000_0000, '0, P1M, "mid_change_old");
    conv('0, P1M, 32'h4000_0000, 1024, "mid_change_new");

    // Abort a conversion mid-ITER with an asynchronous reset.
    x = N1M;
    y = N1M;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_angle("async_reset_phase", phase, 32'h0, 0);
    check_int("async_reset_valid", int'(phase_valid), 0);
    seen_since_rst = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    conv(P1M, N1M, 32'hE000_0000, 1024, "after_reset");
    conv(N1M, '0, 32'h8000_0000, 1024, "after_reset_b");

    @(negedge clk);
    check_int("results_pending", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_serial.md
Name: cordic_serial

Overview:
- Iterative (one micro-rotation per clock) CORDIC in vectoring mode.
- Computes the phase atan2(y, x) of a signed 2-D input vector and presents it as a full-circle binary angle.
- Free-running: samples x/y, iterates, publishes the result, then resamples. No start handshake.
- Sits in the datapath behind I/Q-style sample sources that feed a phase detector.

Parameters:
- WIDTH, 32, width of the x/y inputs and of phase.
- ITERS, 24, micro-rotation count (legal 16..30).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- x  input  WIDTH  signed real component; sampled only in LOAD.
- y  input  WIDTH  signed imaginary component; sampled only in LOAD.
- phase  output  WIDTH  binary angle: 2^WIDTH = 360°, two's complement, range [-180°, +180°). 0x40000000 = 90°, 0x80000000 = ±180°.
- phase_valid  output  1  one-cycle pulse in the cycle phase updates.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: phase = 0, phase_valid = 0, FSM = LOAD, iteration counter = 0, internal x/y/z = 0.
- FSM states: LOAD -> ITER (ITERS cycles) -> DONE -> LOAD. Fixed period ITERS+2 cycles (26 at default).
- Latency: x/y are captured at the LOAD edge. The result appears on phase ITERS+1 edges later. Any input held ≥ 2·(ITERS+2) cycles is guaranteed to be reflected.
- Internal datapath: xi and yi are WIDTH+2 bits signed, sign-extended, to absorb CORDIC gain (~1.647) and the √2 growth. z is WIDTH bits and wraps modulo 2^WIDTH.
- LOAD, quadrant pre-rotation:
  - If x ≥ 0: xi = x, yi = y, z = 0.
  - If x < 0 and y ≥ 0: xi = y, yi = -x, z = +90° (0x40000000).
  - If x < 0 and y < 0: xi = -y, yi = x, z = -90° (0xC0000000).
  - Negating the most negative input is exact because of the extended width.
- ITER step i (0..ITERS-1):
  - If yi ≥ 0: xi += yi>>>i, yi -= xi>>>i, z += ATAN[i].
  - Otherwise: xi -= yi>>>i, yi += xi>>>i, z -= ATAN[i].
  - Shifts are arithmetic. All updates use the pre-step values (simultaneous).
- DONE: phase <= z and phase_valid = 1 for this cycle only. phase holds its value until the next DONE.
- ATAN[i] = round(atan(2^-i) · 2^WIDTH / (2π)), e.g. ATAN[0] = 0x20000000, ATAN[1] = 0x12E4051E.
- Accuracy: |phase − ideal| ≤ 1024 LSB (≈ 8.6e-5°) for vectors with magnitude ≥ 2^12. No accuracy requirement below that.
- Boundary cases:
  - x = 0, y = 0: phase = 0 exactly.
  - x < 0, y = 0: phase = 0x80000000 (±1024).
  - x = 0, y > 0: 0x40000000. x = 0, y < 0: 0xC0000000.
- Input changes outside LOAD are ignored. The conversion in flight completes using the captured values.
- Reset asserted mid-conversion aborts it immediately and returns all state to reset values. After release, the first LOAD occurs on the first rising edge.
- No gain compensation. The magnitude is not an output.

Decomposition:
- Package cordic_pkg:
  - ATAN lookup constant array (30 entries, 32-bit).
  - Angle constants ANG_90 = 0x40000000, ANG_M90 = 0xC0000000.
  - FSM state enum {LOAD, ITER, DONE}.
- Optional sub-module cordic_stage_comb: purely combinational single micro-rotation (xi, yi, z, i -> next xi, yi, z). It keeps the FSM/counter in cordic_serial and can be reused by a future pipelined variant.

Test Plan:
- Reset: rst_n low 2 cycles, then high. phase = 0 during reset. First phase_valid exactly ITERS+2 edges after release.
- x = 1000000, y = 1000000 held 30 cycles -> phase = 0x20000000 ±1024; one phase_valid per 26 cycles.
- Hold each for 30 cycles:
  - x = 1000000, y = 0 -> 0x00000000.
  - x = 1000000, y = -1000000 -> 0xE0000000.
  - x = 0, y = 1000000 -> 0x40000000.
  - x = 0, y = -1000000 -> 0xC0000000.
  - All within ±1024 LSB.
- Left half-plane and extremes:
  - x = -1000000, y = 0 -> 0x80000000.
  - x = -1000000, y = -1000000 -> 0xA0000000.
  - x = 0x80000000, y = 0x80000000 (most negative) -> 0xA0000000, no overflow.
  - x = 0, y = 0 -> 0.
- Mid-conversion: change x/y 5 cycles after LOAD -> the next phase reflects the old captured values, the following one the new values. Assert rst_n mid-ITER -> phase clears asynchronously and no stale phase_valid occurs.
